// File: rtl/pipe_pkg.sv
// Shared definitions for the pipe_reg_hs handshake register slice:
// occupancy/state encodings and default widths.
package pipe_pkg;

   localparam int DATA_W_DEF = 32;
   localparam int CNT_W_DEF  = 16;

   // The encoding doubles as the Occ output, so the values are fixed.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } pipe_state_e;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter; holds at all-ones, cleared only by Rst.
module pipe_sat_cnt
   import pipe_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             Clk,
   input  logic             Rst,
   input  logic             Inc,
   output logic [CNT_W-1:0] Cnt
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (Inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign Cnt = cnt_q;

endmodule

// File: rtl/pipe_reg_hs.sv
// Valid/ready pipeline register with flush, bubble and a saturating stall counter.
// Define PIPE_SKID_EN for the two-entry skid buffer (In_Rdy fully registered);
// otherwise a single entry whose In_Rdy passes Out_Rdy through combinationally.
//
// state | meaning
// EMPTY | nothing held, Out_Vld=0
// ONE   | main register holds the head beat
// TWO   | main holds the head beat, skid holds the next (skid build only)
module pipe_reg_hs
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              Flush,
   input  logic              Bubble,
   input  logic              In_Vld,
   output logic              In_Rdy,
   input  logic [DATA_W-1:0] In_Data,
   output logic              Out_Vld,
   input  logic              Out_Rdy,
   output logic [DATA_W-1:0] Out_Data,
   output logic [1:0]        Occ,
   output logic [CNT_W-1:0]  Stall_Cnt
);

   pipe_state_e       state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic              accept, fire;
`ifdef PIPE_SKID_EN
   logic [DATA_W-1:0] skid_q, skid_d;
`endif

   assign Out_Vld  = (state_q != EMPTY);
   assign Out_Data = main_q;
   assign Occ      = state_q;

`ifdef PIPE_SKID_EN
   assign In_Rdy = (state_q != TWO) & ~Flush & ~Bubble & ~Rst;
`else
   assign In_Rdy = (~Out_Vld | Out_Rdy) & ~Flush & ~Bubble & ~Rst;
`endif

   assign accept = In_Vld & In_Rdy;
   assign fire   = Out_Vld & Out_Rdy;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
`ifdef PIPE_SKID_EN
      skid_d  = skid_q;
`endif
      if (Flush) begin
         state_d = EMPTY;
         main_d  = '0;
`ifdef PIPE_SKID_EN
         skid_d  = '0;
`endif
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d = ONE;
                  main_d  = In_Data;
               end
            end
            ONE: begin
`ifdef PIPE_SKID_EN
               if (accept && !fire) begin
                  state_d = TWO;
                  skid_d  = In_Data;
               end else if (accept) begin
                  main_d  = In_Data;
               end else if (fire) begin
                  state_d = EMPTY;
                  main_d  = '0;
               end
`else
               // Accept here implies Out_Rdy, so the head leaves as the new beat lands.
               if (accept) begin
                  main_d  = In_Data;
               end else if (fire) begin
                  state_d = EMPTY;
                  main_d  = '0;
               end
`endif
            end
`ifdef PIPE_SKID_EN
            TWO: begin
               if (fire) begin
                  state_d = ONE;
                  main_d  = skid_q;
                  skid_d  = '0;
               end
            end
`endif
            default: begin
               state_d = EMPTY;
               main_d  = '0;
            end
         endcase
      end
   end

   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q <= EMPTY;
         main_q  <= '0;
`ifdef PIPE_SKID_EN
         skid_q  <= '0;
`endif
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
`ifdef PIPE_SKID_EN
         skid_q  <= skid_d;
`endif
      end
   end

   pipe_sat_cnt #(
      .CNT_W (CNT_W)
   ) u_stall_cnt (
      .Clk (Clk),
      .Rst (Rst),
      .Inc (Out_Vld & ~Out_Rdy),
      .Cnt (Stall_Cnt)
   );

endmodule

// File: tb/tb_pipe_reg_hs.sv
// Self-checking bench for pipe_reg_hs: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_reg_hs;

   localparam int DW = 16;
   localparam int CW = 4;
   localparam int SATMAX = (1 << CW) - 1;
`ifdef PIPE_SKID_EN
   localparam int CAP = 2;
`else
   localparam int CAP = 1;
`endif

   logic          clk = 1'b0;
   logic          rst, flush, bubble, in_vld, out_rdy;
   logic [DW-1:0] in_data;
   logic          in_rdy, out_vld;
   logic [DW-1:0] out_data;
   logic [1:0]    occ;
   logic [CW-1:0] stall_cnt;

   int checks   = 0;
   int failures = 0;

   logic [DW-1:0] mq[$];
   int            mstall = 0;

   always #5 clk = ~clk;

   pipe_reg_hs #(.DATA_W(DW), .CNT_W(CW)) dut (
      .Clk       (clk),
      .Rst       (rst),
      .Flush     (flush),
      .Bubble    (bubble),
      .In_Vld    (in_vld),
      .In_Rdy    (in_rdy),
      .In_Data   (in_data),
      .Out_Vld   (out_vld),
      .Out_Rdy   (out_rdy),
      .Out_Data  (out_data),
      .Occ       (occ),
      .Stall_Cnt (stall_cnt)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Readiness from the model: room in the buffer (or a leaving head in the
   // single-entry build) and no flush/bubble/reset.
   function automatic bit exp_rdy();
      bit room;
      if (CAP == 2) room = (mq.size() < 2);
      else          room = (mq.size() == 0) || out_rdy;
      return room && !flush && !bubble && !rst;
   endfunction

   task automatic compare();
      chk("in_rdy",    in_rdy,    exp_rdy());
      chk("out_vld",   out_vld,   mq.size() > 0);
      chk("out_data",  out_data,  (mq.size() > 0) ? mq[0] : 0);
      chk("occ",       occ,       mq.size());
      chk("stall_cnt", stall_cnt, mstall);
   endtask

   task automatic drive(input bit r, input bit f, input bit b, input bit v,
                        input logic [DW-1:0] d, input bit o);
      @(negedge clk);
      rst = r; flush = f; bubble = b; in_vld = v; in_data = d; out_rdy = o;
      #1;
      compare();
   endtask

   task automatic tick();
      bit acc, fire;
      @(posedge clk);
      if (rst) begin
         mq.delete();
         mstall = 0;
      end else begin
         acc  = in_vld && exp_rdy();
         fire = (mq.size() > 0) && out_rdy;
         if ((mq.size() > 0) && !out_rdy && (mstall < SATMAX)) mstall++;
         if (flush) begin
            mq.delete();
         end else begin
            if (fire) void'(mq.pop_front());
            if (acc)  mq.push_back(in_data);
         end
      end
      #1;
   endtask

   task automatic cyc(input bit r, input bit f, input bit b, input bit v,
                      input logic [DW-1:0] d, input bit o);
      drive(r, f, b, v, d, o);
      tick();
   endtask

   task automatic do_reset();
      cyc(1, 0, 0, 0, '0, 0);
      cyc(1, 0, 0, 0, '0, 0);
   endtask

   initial begin
      rst = 1; flush = 0; bubble = 0; in_vld = 0; in_data = '0; out_rdy = 0;

      // Reset state, then readiness in the first free cycle
      drive(1, 1, 1, 1, 16'h1234, 1);
      chk("rst_in_rdy", in_rdy, 0);
      tick();
      chk("rst_occ", occ, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_stall", stall_cnt, 0);
      drive(0, 0, 0, 0, '0, 1);
      chk("post_rst_in_rdy", in_rdy, 1);
      tick();

      // Streaming 1..10 at full rate
      for (int k = 1; k <= 10; k++) begin
         drive(0, 0, 0, 1, DW'(k), 1);
         if (k > 1) chk("stream_data", out_data, k - 1);
         chk("stream_occ_le1", occ <= 1, 1);
         tick();
      end
      drive(0, 0, 0, 0, '0, 1);
      chk("stream_last", out_data, 10);
      chk("stream_stall", stall_cnt, 0);
      tick();

      // Backpressure: A accepted, B offered while stalled, then drain A,B
      do_reset();
      cyc(0, 0, 0, 1, 16'h00AA, 0);
      cyc(0, 0, 0, 1, 16'h00BB, 0);
      drive(0, 0, 0, 1, 16'h00BB, 0);
      chk("bp_in_rdy", in_rdy, 0);
      tick();
      chk("bp_occ", occ, CAP);
      chk("bp_head", out_data, 16'h00AA);
      chk("bp_stall", stall_cnt, 2);
      cyc(0, 0, 0, 1, 16'h00BB, 1);
      chk("bp_second", out_data, 16'h00BB);
      cyc(0, 0, 0, 0, '0, 1);
      chk("bp_empty", occ, 0);
      chk("bp_stall_hold", stall_cnt, 2);

      // Flush while full with a beat offered
      do_reset();
      cyc(0, 0, 0, 1, 16'h0011, 0);
      cyc(0, 0, 0, 1, 16'h0022, 0);
      cyc(0, 1, 0, 1, 16'h0033, 0);
      chk("flush_occ", occ, 0);
      chk("flush_vld", out_vld, 0);
      chk("flush_data", out_data, 0);
      chk("flush_stall", stall_cnt, 2);
      cyc(0, 0, 0, 0, '0, 1);
      chk("flush_dropped", out_vld, 0);

      // Bubble: held beat drains while upstream is refused
      cyc(0, 0, 0, 1, 16'h0044, 1);
      chk("bub_load", occ, 1);
      drive(0, 0, 1, 1, 16'h0055, 1);
      chk("bub_rdy0", in_rdy, 0);
      tick();
      drive(0, 0, 1, 1, 16'h0055, 1);
      chk("bub_rdy1", in_rdy, 0);
      tick();
      chk("bub_occ", occ, 0);

      // Stall counter saturation
      do_reset();
      cyc(0, 0, 0, 1, 16'h0066, 0);
      for (int k = 0; k < 20; k++) cyc(0, 0, 0, 0, '0, 0);
      chk("sat_stall", stall_cnt, 15);

      // Reset mid-operation while full
      do_reset();
      cyc(0, 0, 0, 1, 16'h0077, 0);
      cyc(0, 0, 0, 1, 16'h0088, 0);
      chk("pre_rst_occ", occ, CAP);
      cyc(1, 0, 0, 1, 16'h0099, 1);
      chk("mid_rst_occ", occ, 0);
      chk("mid_rst_vld", out_vld, 0);
      chk("mid_rst_data", out_data, 0);
      chk("mid_rst_stall", stall_cnt, 0);
      drive(0, 0, 0, 0, '0, 0);
      chk("mid_rst_rdy", in_rdy, 1);
      tick();

      // Randomized traffic
      for (int k = 0; k < 3000; k++) begin
         cyc(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 4),
             ($urandom_range(0, 99) < 10), ($urandom_range(0, 99) < 65),
             DW'($urandom), ($urandom_range(0, 99) < 55));
         if (occ > CAP) chk("rand_occ_cap", occ, CAP);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
